// File: rtl/pipe_stage_skid.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pipe_stage_skid                                                 |
// | Purpose  : Two-entry skid-buffered pipeline stage register carrying PC,    |
// |            PC+4 and a generic payload between two stages of the RV32I      |
// |            core. in_ready is built from registers and start only, so       |
// |            downstream back-pressure never reaches upstream combinationally.|
// | Ports    : clk, reset (async, active-high)                                 |
// |            start        - stage enable; low clears and idles the stage     |
// |            flush        - synchronous clear of both entries                |
// |            in_valid/in_ready, pc_in, pc_plus4_in, data_in   (upstream)     |
// |            out_valid/out_ready, pc_out, pc_plus4_out, data_out (downstream)|
// |            stall_cnt_out, flush_cnt_out (only with STAGE_PERF_CNT_EN)      |
// | Options  : `define STAGE_PERF_CNT_EN adds saturating stall/flush counters. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pipe_stage_skid #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [PC_W-1:0]   pc_plus4_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   pc_out,
  output logic [PC_W-1:0]   pc_plus4_out,
  output logic [DATA_W-1:0] data_out
`ifdef STAGE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_out,
  output logic [CNT_W-1:0]  flush_cnt_out
`endif
);

  generate
    if (PC_W < 1 || DATA_W < 1 || CNT_W < 1) begin : g_param_check
      $error("pipe_stage_skid: PC_W, DATA_W and CNT_W must all be >= 1");
    end
  endgenerate

  localparam logic [1:0] c_empty = 2'd0;  // no beat held
  localparam logic [1:0] c_one   = 2'd1;  // main entry valid
  localparam logic [1:0] c_full  = 2'd2;  // main and skid entries valid

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              w_push;
  logic              w_pop;
  logic              w_clear;

  logic [PC_W-1:0]   r_main_pc;
  logic [PC_W-1:0]   r_main_pc4;
  logic [DATA_W-1:0] r_main_data;
  logic [PC_W-1:0]   r_skid_pc;
  logic [PC_W-1:0]   r_skid_pc4;
  logic [DATA_W-1:0] r_skid_data;

  // Flush and start-low share one clearing path.
  assign w_clear = flush || !start;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_empty;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (w_clear) begin
      w_state_nxt = c_empty;
    end else begin
      case (r_state)
        c_empty: if (w_push) w_state_nxt = c_one;
        c_one: begin
          if (w_push && !w_pop)      w_state_nxt = c_full;
          else if (w_pop && !w_push) w_state_nxt = c_empty;
        end
        c_full:  if (w_pop) w_state_nxt = c_one;
        default: w_state_nxt = c_empty;
      endcase
    end
  end

  // Output logic: in_ready looks only at the state register and start.
  always_comb begin
    in_ready     = start && (r_state != c_full);
    out_valid    = (r_state != c_empty);
    w_push       = in_valid && in_ready;
    w_pop        = out_valid && out_ready;
    pc_out       = '0;
    pc_plus4_out = '0;
    data_out     = '0;
    if (out_valid) begin
      pc_out       = r_main_pc;
      pc_plus4_out = r_main_pc4;
      data_out     = r_main_data;
    end
  end

  // Entry storage. Entries are zeroed whenever they stop holding a beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main_pc   <= '0;
      r_main_pc4  <= '0;
      r_main_data <= '0;
      r_skid_pc   <= '0;
      r_skid_pc4  <= '0;
      r_skid_data <= '0;
    end else if (w_clear) begin
      r_main_pc   <= '0;
      r_main_pc4  <= '0;
      r_main_data <= '0;
      r_skid_pc   <= '0;
      r_skid_pc4  <= '0;
      r_skid_data <= '0;
    end else begin
      case (r_state)
        c_empty: begin
          if (w_push) begin
            r_main_pc   <= pc_in;
            r_main_pc4  <= pc_plus4_in;
            r_main_data <= data_in;
          end
        end
        c_one: begin
          if (w_push && w_pop) begin
            r_main_pc   <= pc_in;
            r_main_pc4  <= pc_plus4_in;
            r_main_data <= data_in;
          end else if (w_push) begin
            r_skid_pc   <= pc_in;
            r_skid_pc4  <= pc_plus4_in;
            r_skid_data <= data_in;
          end else if (w_pop) begin
            r_main_pc   <= '0;
            r_main_pc4  <= '0;
            r_main_data <= '0;
          end
        end
        c_full: begin
          if (w_pop) begin
            r_main_pc   <= r_skid_pc;
            r_main_pc4  <= r_skid_pc4;
            r_main_data <= r_skid_data;
            r_skid_pc   <= '0;
            r_skid_pc4  <= '0;
            r_skid_data <= '0;
          end
        end
        default: begin
          r_main_pc   <= '0;
          r_main_pc4  <= '0;
          r_main_data <= '0;
          r_skid_pc   <= '0;
          r_skid_pc4  <= '0;
          r_skid_data <= '0;
        end
      endcase
    end
  end

`ifdef STAGE_PERF_CNT_EN
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic             w_stall_evt;
  logic             w_flush_evt;

  assign w_stall_evt = start && in_valid && !in_ready;
  // A flush only counts when it actually discards something.
  assign w_flush_evt = start && flush && ((r_state != c_empty) || w_push);

  // Cleared by reset only; flush and start leave the history intact.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_evt && (r_stall_cnt != c_cnt_max)) r_stall_cnt <= r_stall_cnt + c_cnt_one;
      if (w_flush_evt && (r_flush_cnt != c_cnt_max)) r_flush_cnt <= r_flush_cnt + c_cnt_one;
    end
  end

  assign stall_cnt_out = r_stall_cnt;
  assign flush_cnt_out = r_flush_cnt;
`else
  // No performance counters in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pipe_stage_skid                                              |
// | Purpose  : Self-checking bench for pipe_stage_skid: directed scenarios     |
// |            plus randomized traffic against a queue-based reference model.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_pipe_stage_skid;

  localparam int PC_W   = 32;
  localparam int DATA_W = 2;
  localparam int CNT_W  = 2;

  logic              clk;
  logic              reset;
  logic              start;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   pc_in;
  logic [PC_W-1:0]   pc_plus4_in;
  logic [DATA_W-1:0] data_in;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   pc_out;
  logic [PC_W-1:0]   pc_plus4_out;
  logic [DATA_W-1:0] data_out;
`ifdef STAGE_PERF_CNT_EN
  logic [CNT_W-1:0]  stall_cnt_out;
  logic [CNT_W-1:0]  flush_cnt_out;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   pc4;
    logic [DATA_W-1:0] data;
  } beat_t;

  pipe_stage_skid #(
    .PC_W   (PC_W),
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .pc_in        (pc_in),
    .pc_plus4_in  (pc_plus4_in),
    .data_in      (data_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .pc_out       (pc_out),
    .pc_plus4_out (pc_plus4_out),
    .data_out     (data_out)
`ifdef STAGE_PERF_CNT_EN
    ,
    .stall_cnt_out(stall_cnt_out),
    .flush_cnt_out(flush_cnt_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    start = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    pc_in = '0; pc_plus4_in = '0; data_in = '0;
  endtask

  task automatic drive_beat(input logic [PC_W-1:0] pc, input logic [DATA_W-1:0] d);
    in_valid = 1'b1; pc_in = pc; pc_plus4_in = pc + 32'd4; data_in = d;
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || pc_out !== '0 || pc_plus4_out !== '0 || data_out !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b pc=%h pc4=%h d=%b, want all 0",
               out_valid, pc_out, pc_plus4_out, data_out);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
`ifdef STAGE_PERF_CNT_EN
    checks++;
    if (stall_cnt_out !== '0 || flush_cnt_out !== '0) begin
      errors++;
      $display("FAIL reset_counters: got stall=%0d flush=%0d want 0 0", stall_cnt_out, flush_cnt_out);
    end
`endif
    reset = 1'b0;
    tick();
  endtask

  task automatic test_stream();
    logic [PC_W-1:0]   exp_pc;
    logic [DATA_W-1:0] exp_d;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_pc = 32'h100 + 32'(4 * i);
      exp_d  = 2'b10 ^ 2'(i);
      drive_beat(exp_pc, exp_d);
      tick();
      checks++;
      if (out_valid !== 1'b1 || pc_out !== exp_pc || pc_plus4_out !== exp_pc + 32'd4 || data_out !== exp_d) begin
        errors++;
        $display("FAIL stream_beat%0d: got v=%b pc=%h pc4=%h d=%b, want v=1 pc=%h pc4=%h d=%b",
                 i, out_valid, pc_out, pc_plus4_out, data_out, exp_pc, exp_pc + 32'd4, exp_d);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || pc_out !== '0) begin
      errors++;
      $display("FAIL stream_drain: got v=%b pc=%h want v=0 pc=0", out_valid, pc_out);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    drive_beat(32'h200, 2'b01);
    tick();
    drive_beat(32'h204, 2'b11);
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || pc_out !== 32'h200) begin
      errors++;
      $display("FAIL bp_full: got rdy=%b v=%b pc=%h want rdy=0 v=1 pc=00000200", in_ready, out_valid, pc_out);
    end
    // in_ready must not follow out_ready combinationally.
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_comb_path: got rdy=%b want 0", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || pc_out !== 32'h204 || data_out !== 2'b11 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_second: got v=%b pc=%h d=%b rdy=%b want v=1 pc=00000204 d=11 rdy=1",
               out_valid, pc_out, data_out, in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_flush();
    bit seen;
    do_reset();
    out_ready = 1'b0;
    drive_beat(32'h300, 2'b00);
    tick();
    drive_beat(32'h304, 2'b01);
    tick();
    drive_beat(32'h308, 2'b10);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || pc_out !== '0 || pc_plus4_out !== '0 || data_out !== '0) begin
      errors++;
      $display("FAIL flush_clear: got v=%b pc=%h pc4=%h d=%b want all 0",
               out_valid, pc_out, pc_plus4_out, data_out);
    end
    // A push presented together with flush in state ONE is discarded.
    drive_beat(32'h310, 2'b11);
    tick();
    drive_beat(32'h308, 2'b10);
    out_ready = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid === 1'b1) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL flush_push_discarded: got a valid beat after flush, want none");
    end
  endtask

  task automatic test_start_low();
    do_reset();
    out_ready = 1'b1;
    drive_beat(32'h500, 2'b01);
    tick();
    start = 1'b0;
    drive_beat(32'h504, 2'b10);
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL start_low_ready: got %b want 0", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || pc_out !== '0 || data_out !== '0) begin
      errors++;
      $display("FAIL start_low_cycle1: got v=%b rdy=%b pc=%h d=%b want 0 0 0 0", out_valid, in_ready, pc_out, data_out);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || pc_out !== '0) begin
      errors++;
      $display("FAIL start_low_cycle2: got v=%b rdy=%b pc=%h want 0 0 0", out_valid, in_ready, pc_out);
    end
    start = 1'b1;
    drive_beat(32'h508, 2'b11);
    tick();
    checks++;
    if (out_valid !== 1'b1 || pc_out !== 32'h508 || data_out !== 2'b11) begin
      errors++;
      $display("FAIL start_resume: got v=%b pc=%h d=%b want v=1 pc=00000508 d=11", out_valid, pc_out, data_out);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    out_ready = 1'b0;
    drive_beat(32'h400, 2'b10);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || pc_out !== '0 || pc_plus4_out !== '0) begin
      errors++;
      $display("FAIL async_reset: got v=%b pc=%h pc4=%h before clock edge, want 0", out_valid, pc_out, pc_plus4_out);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

`ifdef STAGE_PERF_CNT_EN
  task automatic test_counters();
    do_reset();
    out_ready = 1'b0;
    drive_beat(32'h300, 2'b00);
    tick();
    drive_beat(32'h304, 2'b01);
    tick();
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (stall_cnt_out !== 2'd3 || flush_cnt_out !== 2'd0) begin
      errors++;
      $display("FAIL cnt_stall_sat: got stall=%0d flush=%0d want 3 0", stall_cnt_out, flush_cnt_out);
    end
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    checks++;
    if (flush_cnt_out !== 2'd1 || stall_cnt_out !== 2'd3) begin
      errors++;
      $display("FAIL cnt_flush: got flush=%0d stall=%0d want 1 3", flush_cnt_out, stall_cnt_out);
    end
    // Flushing an empty stage with no push is not counted.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (flush_cnt_out !== 2'd1) begin
      errors++;
      $display("FAIL cnt_flush_empty: got %0d want 1", flush_cnt_out);
    end
  endtask
`endif

  // Randomized traffic against a capacity-2 FIFO model.
  task automatic test_random();
    beat_t q[$];
    beat_t b;
    beat_t exp_b;
    bit    exp_rdy;
    bit    exp_vld;
    bit    push;
    bit    pop;
    int    stall_m;
    int    flush_m;
    do_reset();
    stall_m = 0;
    flush_m = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      start     = ($urandom_range(0, 19) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_valid  = $urandom_range(0, 1);
      out_ready = $urandom_range(0, 1);
      b.pc      = $urandom;
      b.pc4     = b.pc + 32'd4;
      b.data    = DATA_W'($urandom);
      pc_in       = b.pc;
      pc_plus4_in = b.pc4;
      data_in     = b.data;
      #1;
      exp_rdy = start && (q.size() < 2);
      exp_vld = (q.size() != 0);
      exp_b   = exp_vld ? q[0] : '0;
      checks++;
      if (in_ready !== exp_rdy || out_valid !== exp_vld || pc_out !== exp_b.pc ||
          pc_plus4_out !== exp_b.pc4 || data_out !== exp_b.data) begin
        errors++;
        $display("FAIL random_cyc%0d: got rdy=%b v=%b pc=%h pc4=%h d=%b want rdy=%b v=%b pc=%h pc4=%h d=%b",
                 cyc, in_ready, out_valid, pc_out, pc_plus4_out, data_out,
                 exp_rdy, exp_vld, exp_b.pc, exp_b.pc4, exp_b.data);
      end
      push = in_valid && exp_rdy;
      pop  = exp_vld && out_ready;
      if (start && in_valid && !exp_rdy && stall_m < (1 << CNT_W) - 1) stall_m++;
      if (start && flush && (q.size() != 0 || push) && flush_m < (1 << CNT_W) - 1) flush_m++;
      if (!start || flush) begin
        q.delete();
      end else begin
        if (pop) void'(q.pop_front());
        if (push) q.push_back(b);
      end
      tick();
`ifdef STAGE_PERF_CNT_EN
      checks++;
      if (stall_cnt_out !== CNT_W'(stall_m) || flush_cnt_out !== CNT_W'(flush_m)) begin
        errors++;
        $display("FAIL random_cnt_cyc%0d: got stall=%0d flush=%0d want %0d %0d",
                 cyc, stall_cnt_out, flush_cnt_out, stall_m, flush_m);
      end
`endif
    end
    drive_idle();
  endtask

  initial begin
    reset = 1'b1;
    drive_idle();
    tick();
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_start_low();
    test_async_reset();
`ifdef STAGE_PERF_CNT_EN
    test_counters();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fetch/decode pipeline register.
- A 2-entry skid-buffered stage register carrying PC, PC+4 and a generic control/data payload, with valid/ready handshakes on both sides.
- Adds a flush input and a registered-only `in_ready` path, so back-pressure never forms a combinational path from `out_ready` to `in_ready`.
- Sits between any two pipeline stages (IF/ID, ID/EX, ...) of the RV32I core.

Parameters:
- PC_W, 32, width of `pc_in`/`pc_out` and `pc_plus4_in`/`pc_plus4_out`.
- DATA_W, 2, width of the generic payload (e.g. {load_temp, plus1}); minimum 1.
- CNT_W, 16, width of the performance counters (used only with STAGE_PERF_CNT_EN).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  stage enable; low = stage idle and cleared
- flush  input  1  synchronous flush (e.g. branch taken)
- in_valid  input  1  upstream beat valid
- in_ready  output  1  stage can accept a beat
- pc_in  input  PC_W  upstream PC
- pc_plus4_in  input  PC_W  upstream PC+4
- data_in  input  DATA_W  upstream payload
- out_valid  output  1  downstream beat valid
- out_ready  input  1  downstream accepts the beat
- pc_out  output  PC_W  registered PC
- pc_plus4_out  output  PC_W  registered PC+4
- data_out  output  DATA_W  registered payload
- stall_cnt_out  output  CNT_W  only with STAGE_PERF_CNT_EN
- flush_cnt_out  output  CNT_W  only with STAGE_PERF_CNT_EN

Behaviour:
- Storage:
  - main entry drives the outputs;
  - skid entry holds a second beat;
  - state encoded EMPTY / ONE / FULL.
- Handshake signals:
  - push = in_valid && in_ready.
  - pop = out_valid && out_ready.
  - in_ready = start && (state != FULL). It depends only on registers and `start`, never on `out_ready`.
  - out_valid = (state != EMPTY).
- Reset (async, active-high): state EMPTY; all payload registers 0; out_valid 0; counters 0.
- Payload outputs (`pc_out`, `pc_plus4_out`, `data_out`) are all-zero whenever out_valid = 0.
- State transitions (apply when start = 1 and flush = 0):
  - EMPTY: push -> ONE, main <= in.
  - ONE:
    - push && !pop -> FULL, skid <= in.
    - pop && !push -> EMPTY, main <= 0.
    - push && pop -> ONE, main <= in.
    - neither -> hold.
  - FULL:
    - pop -> ONE, main <= skid, skid <= 0.
    - no pop -> hold. A push cannot occur (in_ready = 0).
- Latency: a beat accepted in cycle N appears on the outputs with out_valid = 1 in cycle N+1 when the stage was EMPTY, or when it was ONE with a pop in cycle N.
- Throughput: 1 beat/cycle while out_ready stays high.
- Ordering: strict FIFO; no beat is duplicated or dropped except by flush or start low.
- flush = 1 (start = 1): next state EMPTY, both entries cleared to 0.
  - A push in the same cycle is discarded.
  - A pop in the same cycle still counts as a completed transfer for the downstream stage.
- start = 0: same clearing as flush; in_ready = 0; the stage stays EMPTY while start is low.
- flush and start low in the same cycle: identical result (EMPTY, cleared).
- Reset asserted mid-operation: in-flight beats are lost immediately (asynchronous), with no partial update.
- PC values are passed through unmodified; no arithmetic is performed on them.

Optional Feature:
- Macro: STAGE_PERF_CNT_EN.
- When defined:
  - stall_cnt_out increments each cycle with start && in_valid && !in_ready.
  - flush_cnt_out increments each cycle with start && flush && (state != EMPTY || push).
  - Both saturate at 2^CNT_W-1.
  - Both are cleared by reset only; flush and start do not clear them.
- When not defined: neither counter port exists, and no counter logic is generated.

Test Plan:
- Reset, then start = 1, in_valid = 1, pc_in = 0x100, pc_plus4_in = 0x104, data_in = 2'b10, out_ready = 1 -> next cycle out_valid = 1, pc_out = 0x100, pc_plus4_out = 0x104, data_out = 2'b10; a 4-beat stream 0x100..0x10C emerges at one beat per cycle, in order.
- out_ready = 0, push 0x200 then 0x204 -> state FULL, in_ready = 0, pc_out = 0x200; raise out_ready -> 0x200 then 0x204 delivered on consecutive cycles, in_ready = 1 again in the cycle after the first pop.
- State FULL (0x300, 0x304), then flush = 1 for 1 cycle with in_valid = 1, pc_in = 0x308 -> next cycle out_valid = 0, all outputs 0, 0x308 never appears.
- Streaming with start dropped to 0 for 2 cycles -> in_ready = 0 and out_valid = 0, outputs all zero during those cycles; beats resume correctly after start returns to 1.
- Assert reset asynchronously mid-clock while in state ONE holding 0x400 -> out_valid and pc_out go to 0 before the next clock edge.
- With STAGE_PERF_CNT_EN, CNT_W = 2: hold FULL with in_valid = 1 for 5 cycles -> stall_cnt_out = 3 (saturated); 1 flush while non-empty -> flush_cnt_out = 1.
